// File: rtl/edge_det_pkg.sv
// rtl/edge_det_pkg.sv - shared types and helpers for the edge event detector
// Mode encoding and the saturating increment used by every channel counter.
package edge_det_pkg;

   typedef enum logic [1:0] {
      DET_POS   = 2'b00,
      DET_NEG   = 2'b01,
      DET_ANY   = 2'b10,
      DET_LEVEL = 2'b11
   } det_mode_e;

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] top;
      top = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      return (v == top) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/edge_det_channel.sv
// rtl/edge_det_channel.sv - one channel: synchroniser, optional filter, detect, pending, count
// Glitch filter present only when EDGE_DET_FILTER_EN is defined.
module edge_det_channel
   import edge_det_pkg::*;
#(
   parameter int CW          = 8,
   parameter int SYNC_STAGES = 2
`ifdef EDGE_DET_FILTER_EN
   ,
   parameter int FILTER_LEN  = 3
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inp,
   input  logic          en,
   input  logic [1:0]    mode,
   input  logic          clr,
   input  logic          arm,
   output logic          pending,
   output logic [CW-1:0] count
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   prev_q;
   logic                   pending_q, pending_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   hit;
   logic                   ev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], inp};
      end
   end

`ifdef EDGE_DET_FILTER_EN
   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);

   logic          s_q, s_d;
   logic [FW-1:0] fcnt_q, fcnt_d;

   // fcnt_q counts consecutive cycles the synchroniser disagrees with s
   always_comb begin
      s_d    = s_q;
      fcnt_d = fcnt_q;
      if (sync_q[SYNC_STAGES-1] == s_q) begin
         fcnt_d = '0;
      end else if (fcnt_q == FMAX) begin
         s_d    = sync_q[SYNC_STAGES-1];
         fcnt_d = '0;
      end else begin
         fcnt_d = fcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q    <= 1'b0;
         fcnt_q <= '0;
      end else begin
         s_q    <= s_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign s = s_q;
`else
   assign s = sync_q[SYNC_STAGES-1];
`endif

   always_comb begin
      hit = 1'b0;
      case (det_mode_e'(mode))
         DET_POS:   hit = s & ~prev_q;
         DET_NEG:   hit = ~s & prev_q;
         DET_ANY:   hit = s ^ prev_q;
         DET_LEVEL: hit = s;
         default:   hit = 1'b0;
      endcase
   end

   assign ev = arm & en & hit;

   always_comb begin
      pending_d = pending_q;
      count_d   = count_q;
      if (clr && ev) begin
         pending_d = 1'b1;
         count_d   = CW'(1);
      end else if (clr) begin
         pending_d = 1'b0;
         count_d   = '0;
      end else if (ev) begin
         pending_d = 1'b1;
         count_d   = CW'(sat_inc(32'(count_q), CW));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q    <= 1'b0;
         pending_q <= 1'b0;
         count_q   <= '0;
      end else begin
         prev_q    <= s;
         pending_q <= pending_d;
         count_q   <= count_d;
      end
   end

   assign pending = pending_q;
   assign count   = count_q;

endmodule

// File: rtl/edge_event_detector.sv
// rtl/edge_event_detector.sv - multi-channel edge/level event detector with sticky flags and counters
// Define EDGE_DET_FILTER_EN to insert a per-channel glitch filter of FILTER_LEN cycles.
module edge_event_detector
   import edge_det_pkg::*;
#(
   parameter int CH          = 4,
   parameter int CW          = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CH-1:0]     inp,
   input  logic [CH-1:0]     en,
   input  logic [2*CH-1:0]   mode,
   input  logic [CH-1:0]     clr,
   output logic [CH-1:0]     pending,
   output logic [CH*CW-1:0]  count,
   output logic              irq
);

`ifdef EDGE_DET_FILTER_EN
   localparam int FILT_LAT = FILTER_LEN;
`else
   // FILTER_LEN has no effect without the filter
   localparam int FILT_LAT = 0 * FILTER_LEN;
`endif
   localparam int WARM = SYNC_STAGES + FILT_LAT + 1;
   localparam int WW   = $clog2(WARM + 1);
   localparam logic [WW-1:0] WARM_END = WW'(WARM);

   logic [WW-1:0] warm_q, warm_d;
   logic          arm;

   assign arm    = (warm_q == WARM_END);
   assign warm_d = arm ? warm_q : warm_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         warm_q <= '0;
      end else begin
         warm_q <= warm_d;
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      edge_det_channel #(
         .CW          (CW),
         .SYNC_STAGES (SYNC_STAGES)
`ifdef EDGE_DET_FILTER_EN
         ,
         .FILTER_LEN  (FILTER_LEN)
`endif
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .inp     (inp[i]),
         .en      (en[i]),
         .mode    (mode[2*i +: 2]),
         .clr     (clr[i]),
         .arm     (arm),
         .pending (pending[i]),
         .count   (count[CW*i +: CW])
      );
   end

   assign irq = |pending;

endmodule

// File: tb/tb_edge_event_detector.sv
// tb/tb_edge_event_detector.sv - randomized and directed bench with a history-based reference model
module tb_edge_event_detector;

   localparam int CH   = 4;
   localparam int CW   = 4;
   localparam int SS   = 2;
   localparam int FL   = 3;
`ifdef EDGE_DET_FILTER_EN
   localparam int FLAT = FL;
`else
   localparam int FLAT = 0;
`endif
   localparam int WARM = SS + FLAT + 1;
   localparam int HD   = SS + FL + 2;
   localparam int MAXC = (1 << CW) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [CH-1:0]    inp = '0;
   logic [CH-1:0]    en = '0;
   logic [2*CH-1:0]  mode = '0;
   logic [CH-1:0]    clr = '0;
   logic [CH-1:0]    pending;
   logic [CH*CW-1:0] count;
   logic             irq;

   int n_tests = 0;
   int n_fail  = 0;

   bit h [CH][HD];
   bit fold [CH];
   bit mp [CH];
   int mc [CH];
   int ecnt;

   edge_event_detector #(
      .CH(CH), .CW(CW), .SYNC_STAGES(SS), .FILTER_LEN(FL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .inp(inp), .en(en), .mode(mode), .clr(clr),
      .pending(pending), .count(count), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      ecnt = 0;
      for (int c = 0; c < CH; c++) begin
         for (int k = 0; k < HD; k++) h[c][k] = 1'b0;
         fold[c] = 1'b0;
         mp[c]   = 1'b0;
         mc[c]   = 0;
      end
   endtask

   // s at an edge is the input sampled SS edges earlier (optionally debounced)
   task automatic model_edge();
      bit fnew, sv, pv, hit, ev, same;
      int m;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (ecnt < 1000) ecnt++;
      for (int c = 0; c < CH; c++) begin
         for (int k = HD - 1; k > 0; k--) h[c][k] = h[c][k-1];
         h[c][0] = inp[c];
`ifdef EDGE_DET_FILTER_EN
         same = 1'b1;
         for (int k = SS + 1; k <= SS + FL; k++) if (h[c][k] != h[c][SS+1]) same = 1'b0;
         fnew = same ? h[c][SS+1] : fold[c];
`else
         same = 1'b1;
         fnew = h[c][SS] & same;
`endif
         sv = fnew;
         pv = fold[c];
         fold[c] = fnew;
         m = int'(mode[2*c +: 2]);
         case (m)
            0: hit = sv && !pv;
            1: hit = !sv && pv;
            2: hit = sv != pv;
            default: hit = sv;
         endcase
         ev = en[c] && hit && (ecnt > WARM);
         if (clr[c] && ev) begin
            mp[c] = 1'b1; mc[c] = 1;
         end else if (clr[c]) begin
            mp[c] = 1'b0; mc[c] = 0;
         end else if (ev) begin
            mp[c] = 1'b1;
            if (mc[c] < MAXC) mc[c]++;
         end
      end
   endtask

   task automatic compare();
      bit any;
      any = 1'b0;
      for (int c = 0; c < CH; c++) begin
         check($sformatf("pend%0d", c), int'(pending[c]), int'(mp[c]));
         check($sformatf("cnt%0d", c), int'(count[CW*c +: CW]), mc[c]);
         any |= mp[c];
      end
      check("irq", int'(irq), int'(any));
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
         compare();
      end
   endtask

   function automatic int cnt_of(input int c);
      return int'(count[CW*c +: CW]);
   endfunction

   initial begin
      model_reset();
      // 1: inputs high through reset release give no edge event
      inp = 4'hF; mode = 8'h00; en = 4'hF;
      tick(3);
      rst_n = 1'b1;
      tick(10);
      check("t1_pending", int'(pending), 0);
      check("t1_count", int'(count), 0);
      check("t1_irq", int'(irq), 0);

      // 2: latency of a single rising edge
      inp = 4'h0;
      tick(6);
      clr = 4'hF; tick(1); clr = 4'h0;
      inp[0] = 1'b1;
      tick(SS + FLAT);
      check("t2_early_pend0", int'(pending[0]), 0);
      tick(1);
      check("t2_pend0", int'(pending[0]), 1);
      check("t2_cnt0", cnt_of(0), 1);
      inp[0] = 1'b0;
      tick(8);
      check("t2_cnt0_after_fall", cnt_of(0), 1);

      // 3: any-edge on ch1, neg-edge on ch2
      mode = 8'b00_01_10_00;
      for (int i = 0; i < 4; i++) begin
         inp[1] = ~inp[1]; inp[2] = ~inp[2];
         tick(5);
      end
      tick(8);
      check("t3_cnt1", cnt_of(1), 4);
      check("t3_cnt2", cnt_of(2), 2);
      check("t3_irq", int'(irq), 1);
      check("t3_model_cnt1", mc[1], 4);
      check("t3_model_cnt2", mc[2], 2);

      // 4: level mode saturates, clear empties
      mode[7:6] = 2'b11;
      inp[3] = 1'b1;
      tick(22);
      check("t4_cnt3_sat", cnt_of(3), 15);
      check("t4_model_cnt3", mc[3], 15);
      inp[3] = 1'b0;
      tick(8);
      clr[3] = 1'b1; tick(1); clr[3] = 1'b0;
      check("t4_cnt3_clr", cnt_of(3), 0);
      check("t4_pend3_clr", int'(pending[3]), 0);

      // 5: clear coincident with an event, then async reset mid-cycle
      inp[0] = 1'b1; tick(6); inp[0] = 1'b0; tick(8);
      check("t5_cnt0_pre", cnt_of(0), 2);
      inp[0] = 1'b1;
      tick(SS + FLAT);
      clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
      check("t5_pend0", int'(pending[0]), 1);
      check("t5_cnt0", cnt_of(0), 1);
      inp[3] = 1'b1;
      tick(SS + FLAT + 4);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_pending", int'(pending), 0);
      check("t5_rst_count", int'(count), 0);
      check("t5_rst_irq", int'(irq), 0);
      model_reset();
      @(negedge clk);
      tick(2);
      inp = 4'h0; mode = 8'h00;
      rst_n = 1'b1;
      tick(SS + FL + 4);

      // 6: short pulse vs filter
      inp[0] = 1'b1; tick(2); inp[0] = 1'b0; tick(10);
`ifdef EDGE_DET_FILTER_EN
      check("t6_short_cnt0", cnt_of(0), 0);
`else
      check("t6_short_cnt0", cnt_of(0), 1);
`endif
      inp[0] = 1'b1; tick(5); inp[0] = 1'b0; tick(10);
`ifdef EDGE_DET_FILTER_EN
      check("t6_long_cnt0", cnt_of(0), 1);
`else
      check("t6_long_cnt0", cnt_of(0), 2);
`endif

      // random traffic checked every cycle against the model
      for (int i = 0; i < 600; i++) begin
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(3) == 0) inp[c] = ~inp[c];
            clr[c] = ($urandom_range(23) == 0);
            if ($urandom_range(15) == 0) en[c] = ~en[c];
         end
         if ($urandom_range(11) == 0) mode = 8'($urandom);
         tick(1);
      end
      clr = '0;
      tick(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
